shift_controller: RTL and testbench

SHIFT_CONTROLLER -- requirements
Module: shift_controller

---
 rtl/shift_controller.sv | 129 ++++++++++++
 tb/tb_shift_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_controller.sv
// LSB-first parallel-to-serial controller with per-bit hold timer and enable pause.
// Optional trailing even-parity bit when SHIFT_CONTROLLER_PARITY_EN is defined.
module shift_controller #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             enable,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned TIMER_W = 8;
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(BIT_CYCLES - 1);

`ifdef SHIFT_CONTROLLER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 bit_end;
`ifdef SHIFT_CONTROLLER_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // A serial bit finishes on the last enabled cycle of its hold window
  assign bit_end = enable && (timer_q == LAST_TICK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
`ifdef SHIFT_CONTROLLER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
`ifdef SHIFT_CONTROLLER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Outputs decode from registered state; serial_valid follows enable live
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    timer_d      = timer_q;
`ifdef SHIFT_CONTROLLER_PARITY_EN
    parity_d     = parity_q;
`endif
    load_ready   = 1'b0;
    busy         = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift_d   = load_data;
          bit_cnt_d = '0;
          timer_d   = '0;
`ifdef SHIFT_CONTROLLER_PARITY_EN
          parity_d  = ^load_data;
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        busy         = 1'b1;
        serial_out   = shift_q[0];
        serial_valid = enable;
        if (enable) timer_d = timer_q + TIMER_W'(1);
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          timer_d   = '0;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SHIFT_CONTROLLER_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef SHIFT_CONTROLLER_PARITY_EN
      PARITY: begin
        busy         = 1'b1;
        serial_out   = parity_q;
        serial_valid = enable;
        if (enable) timer_d = timer_q + TIMER_W'(1);
        if (bit_end) begin
          timer_d = '0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_controller.sv
// Directed bench for shift_controller: two instances (BIT_CYCLES=1 and 3), hand-computed vectors.
// Honours SHIFT_CONTROLLER_PARITY_EN by expecting the trailing parity bit.
module tb_shift_controller;

  logic       clock;
  logic       reset_n;

  logic       lv1, en1, lr1, so1, sv1, bz1, dn1;
  logic [3:0] ld1;
  logic       lv3, en3, lr3, so3, sv3, bz3, dn3;
  logic [3:0] ld3;

  int cmp_cnt = 0;
  int err_cnt = 0;

  shift_controller #(.WIDTH(4), .BIT_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .load_valid(lv1), .load_ready(lr1),
    .load_data(ld1), .enable(en1), .serial_out(so1), .serial_valid(sv1),
    .busy(bz1), .done(dn1)
  );

  shift_controller #(.WIDTH(4), .BIT_CYCLES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .load_valid(lv3), .load_ready(lr3),
    .load_data(ld3), .enable(en3), .serial_out(so3), .serial_valid(sv3),
    .busy(bz3), .done(dn3)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic so, input logic sv,
                      input logic bz, input logic dn, input logic lr);
    chk({tag, ".so1"}, 32'(so1), 32'(so));
    chk({tag, ".sv1"}, 32'(sv1), 32'(sv));
    chk({tag, ".bz1"}, 32'(bz1), 32'(bz));
    chk({tag, ".dn1"}, 32'(dn1), 32'(dn));
    chk({tag, ".lr1"}, 32'(lr1), 32'(lr));
  endtask

  task automatic chk3(input string tag, input logic so, input logic sv,
                      input logic bz, input logic dn, input logic lr);
    chk({tag, ".so3"}, 32'(so3), 32'(so));
    chk({tag, ".sv3"}, 32'(sv3), 32'(sv));
    chk({tag, ".bz3"}, 32'(bz3), 32'(bz));
    chk({tag, ".dn3"}, 32'(dn3), 32'(dn));
    chk({tag, ".lr3"}, 32'(lr3), 32'(lr));
  endtask

  // Optional parity cycle, then the single DONE cycle; leaves bench in the following IDLE cycle
  task automatic end1(input string tag, input logic par);
`ifdef SHIFT_CONTROLLER_PARITY_EN
    chk1({tag, ".par"}, par, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
`else
    if (par) begin end
`endif
    chk1({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk1({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] exp_w;
    clock = 1'b0;
    reset_n = 1'b0;
    lv1 = 1'b0; ld1 = 4'h0; en1 = 1'b1;
    lv3 = 1'b0; ld3 = 4'h0; en3 = 1'b1;

    // Reset values before any clock edge
    #2;
    chk1("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk3("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #10 reset_n = 1'b1;

    // Basic frame 1011 -> 1,1,0,1 then done
    lv1 = 1'b1; ld1 = 4'b1011;
    tick();
    lv1 = 1'b0;
    exp_w = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("basic.b%0d", i), exp_w[i], 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    end1("basic", 1'b1);

    // Pause two cycles during bit 2 of 0100 (bits 0,0,1,0)
    lv1 = 1'b1; ld1 = 4'b0100;
    tick();
    lv1 = 1'b0;
    chk1("pause.b0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk1("pause.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    en1 = 1'b0; #1;
    chk1("pause.h0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk1("pause.h1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    en1 = 1'b1; #1;
    chk1("pause.b2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk1("pause.b3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    end1("pause", 1'b1);

    // load_valid held with 1111 during a 0101 frame: ignored until the next IDLE edge
    lv1 = 1'b1; ld1 = 4'b0101;
    tick();
    ld1 = 4'b1111;
    exp_w = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("hold.b%0d", i), exp_w[i], 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    end1("hold", 1'b0);
    tick();
    lv1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("next.b%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    end1("next", 1'b0);

    // Reset mid-frame (cycle N+2), then reload 0001 on first edge after release
    lv1 = 1'b1; ld1 = 4'b0110;
    tick();
    lv1 = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk1("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk1("arst.edge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b1;
    lv1 = 1'b1; ld1 = 4'b0001;
    tick();
    lv1 = 1'b0;
    exp_w = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("post.b%0d", i), exp_w[i], 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    end1("post", 1'b1);

    // BIT_CYCLES=3, 0110: each bit held 3 enabled cycles; one paused cycle inside bit 1
    lv3 = 1'b1; ld3 = 4'b0110;
    tick();
    lv3 = 1'b0;
    exp_w = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      for (int h = 0; h < 3; h++) begin
        if (b == 1 && h == 1) begin
          en3 = 1'b0; #1;
          chk3("bc3.pause", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
          tick();
          en3 = 1'b1; #1;
        end
        chk3($sformatf("bc3.b%0d.h%0d", b, h), exp_w[b], 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
`ifdef SHIFT_CONTROLLER_PARITY_EN
    for (int h = 0; h < 3; h++) begin
      chk3($sformatf("bc3.par.h%0d", h), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
`endif
    chk3("bc3.done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk3("bc3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
